// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding from EX/MEM and MEM/WB.
// Drives the ALU operands, store data, destination register and gated write-back controls.
module id_ex_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [WIDTH-1:0]   id_rd1,
    input  logic [WIDTH-1:0]   id_rd2,
    input  logic [WIDTH-1:0]   id_imm,
    input  logic [REGBITS-1:0] id_rs,
    input  logic [REGBITS-1:0] id_rt,
    input  logic [REGBITS-1:0] id_rd,
    input  logic [2:0]         id_alu_control,
    input  logic               id_alu_src,
    input  logic               id_reg_dst,
    input  logic               id_reg_write,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               exm_reg_write,
    input  logic [REGBITS-1:0] exm_rd,
    input  logic [WIDTH-1:0]   exm_result,
    input  logic               wb_reg_write,
    input  logic [REGBITS-1:0] wb_rd,
    input  logic [WIDTH-1:0]   wb_result,
    output logic [WIDTH-1:0]   srcA,
    output logic [WIDTH-1:0]   srcB,
    output logic [2:0]         ALUControl,
    output logic               ex_valid,
    output logic [WIDTH-1:0]   ex_write_data,
    output logic [REGBITS-1:0] ex_write_reg,
    output logic               ex_reg_write,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_illegal_op
);

    logic               valid_q;
    logic [WIDTH-1:0]   rd1_q, rd2_q, imm_q;
    logic [REGBITS-1:0] rs_q, rt_q, rd_q;
    logic [2:0]         alu_control_q;
    logic               alu_src_q, reg_dst_q;
    logic               reg_write_q, mem_write_q, mem_to_reg_q;

    // Control fields: a flush turns the slot into a bubble, a stall holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            alu_control_q <= 3'b000;
            reg_write_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
        end else if (flush) begin
            valid_q       <= 1'b0;
            alu_control_q <= 3'b000;
            reg_write_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
        end else if (!stall) begin
            valid_q       <= id_valid;
            alu_control_q <= id_alu_control;
            reg_write_q   <= id_reg_write;
            mem_write_q   <= id_mem_write;
            mem_to_reg_q  <= id_mem_to_reg;
        end
    end

    // Data fields are don't-care in a bubble, so a flush simply loads them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            alu_src_q <= 1'b0;
            reg_dst_q <= 1'b0;
        end else if (flush || !stall) begin
            rd1_q     <= id_rd1;
            rd2_q     <= id_rd2;
            imm_q     <= id_imm;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            rd_q      <= id_rd;
            alu_src_q <= id_alu_src;
            reg_dst_q <= id_reg_dst;
        end
    end

    logic             exm_hit_a, exm_hit_b, wb_hit_a, wb_hit_b;
    logic [WIDTH-1:0] fwd_a, fwd_b;

    // Register 0 is hard-wired to zero and must never be forwarded.
    assign exm_hit_a = exm_reg_write && (exm_rd != '0) && (exm_rd == rs_q);
    assign exm_hit_b = exm_reg_write && (exm_rd != '0) && (exm_rd == rt_q);
    assign wb_hit_a  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs_q);
    assign wb_hit_b  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rt_q);

    assign fwd_a = exm_hit_a ? exm_result : (wb_hit_a ? wb_result : rd1_q);
    assign fwd_b = exm_hit_b ? exm_result : (wb_hit_b ? wb_result : rd2_q);

    assign srcA          = fwd_a;
    assign srcB          = alu_src_q ? imm_q : fwd_b;
    assign ALUControl    = alu_control_q;
    assign ex_valid      = valid_q;
    assign ex_write_data = fwd_b;
    assign ex_write_reg  = reg_dst_q ? rd_q : rt_q;

    assign ex_illegal_op = valid_q && (alu_control_q > 3'b100);
    assign ex_reg_write  = reg_write_q  && valid_q && !ex_illegal_op;
    assign ex_mem_write  = mem_write_q  && valid_q && !ex_illegal_op;
    assign ex_mem_to_reg = mem_to_reg_q && valid_q && !ex_illegal_op;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus random traffic
// compared against a behavioural model of the held instruction.
module tb_id_ex_operand_stage;

    localparam int W = 32;
    localparam int R = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         stall, flush, id_valid;
    logic [W-1:0] id_rd1, id_rd2, id_imm;
    logic [R-1:0] id_rs, id_rt, id_rd;
    logic [2:0]   id_alu_control;
    logic         id_alu_src, id_reg_dst, id_reg_write, id_mem_write, id_mem_to_reg;
    logic         exm_reg_write, wb_reg_write;
    logic [R-1:0] exm_rd, wb_rd;
    logic [W-1:0] exm_result, wb_result;
    logic [W-1:0] srcA, srcB, ex_write_data;
    logic [2:0]   ALUControl;
    logic         ex_valid, ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_illegal_op;
    logic [R-1:0] ex_write_reg;

    id_ex_operand_stage #(.WIDTH(W), .REGBITS(R)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_control(id_alu_control),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .srcA(srcA), .srcB(srcB), .ALUControl(ALUControl), .ex_valid(ex_valid),
        .ex_write_data(ex_write_data), .ex_write_reg(ex_write_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal_op(ex_illegal_op)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: the instruction held by the stage ----------------
    logic         m_valid, m_known;
    logic [W-1:0] m_rd1, m_rd2, m_imm;
    logic [R-1:0] m_rs, m_rt, m_rd;
    logic [2:0]   m_op;
    logic         m_alu_src, m_reg_dst, m_rw, m_mw, m_m2r;

    task automatic model_reset();
        m_valid = 0; m_known = 1; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_op = 0; m_alu_src = 0; m_reg_dst = 0;
        m_rw = 0; m_mw = 0; m_m2r = 0;
    endtask

    task automatic model_clock();
        if (flush) begin
            m_valid = 0; m_rw = 0; m_mw = 0; m_m2r = 0; m_op = 0; m_known = 0;
        end else if (!stall) begin
            m_valid = id_valid; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_op = id_alu_control;
            m_alu_src = id_alu_src; m_reg_dst = id_reg_dst;
            m_rw = id_reg_write; m_mw = id_mem_write; m_m2r = id_mem_to_reg;
            m_known = 1;
        end
    endtask

    // Value the ALU should see for source register idx whose file read was rf.
    function automatic logic [W-1:0] operand(input logic [R-1:0] idx, input logic [W-1:0] rf);
        if (idx == 0) return rf;
        if (exm_reg_write && exm_rd == idx) return exm_result;
        if (wb_reg_write && wb_rd == idx) return wb_result;
        return rf;
    endfunction

    task automatic verify();
        logic ill;
        logic [W-1:0] b;
        #1;
        ill = m_valid && (m_op inside {3'd5, 3'd6, 3'd7});
        check("ex_valid", ex_valid, m_valid);
        check("alu_control", ALUControl, m_op);
        check("illegal", ex_illegal_op, ill);
        check("reg_write", ex_reg_write, m_rw && m_valid && !ill);
        check("mem_write", ex_mem_write, m_mw && m_valid && !ill);
        check("mem_to_reg", ex_mem_to_reg, m_m2r && m_valid && !ill);
        if (m_known) begin
            b = operand(m_rt, m_rd2);
            exp_q.push_back(operand(m_rs, m_rd1));
            exp_q.push_back(m_alu_src ? m_imm : b);
            exp_q.push_back(b);
            exp_q.push_back(m_reg_dst ? m_rd : m_rt);
            check("srcA", srcA, exp_q.pop_front());
            check("srcB", srcB, exp_q.pop_front());
            check("write_data", ex_write_data, exp_q.pop_front());
            check("write_reg", ex_write_reg, exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] imm, input logic [R-1:0] rs, input logic [R-1:0] rt,
                          input logic [R-1:0] rd, input logic [2:0] op, input logic asrc,
                          input logic rdst, input logic rw, input logic mw, input logic m2r);
        id_valid = v; id_rd1 = a; id_rd2 = b; id_imm = imm; id_rs = rs; id_rt = rt; id_rd = rd;
        id_alu_control = op; id_alu_src = asrc; id_reg_dst = rdst;
        id_reg_write = rw; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic set_fwd(input logic erw, input logic [R-1:0] erd, input logic [W-1:0] eres,
                           input logic wrw, input logic [R-1:0] wrd, input logic [W-1:0] wres);
        exm_reg_write = erw; exm_rd = erd; exm_result = eres;
        wb_reg_write = wrw; wb_rd = wrd; wb_result = wres;
    endtask

    task automatic randomize_inputs();
        set_id($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31),
               $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        set_fwd($urandom_range(0, 1), $urandom_range(0, 3), $urandom,
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom);
        stall = ($urandom_range(0, 4) == 0);
        flush = ($urandom_range(0, 7) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        stall = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check("reset_srcA", srcA, 0);
        check("reset_srcB", srcB, 0);
        verify();
        @(negedge clk);
        rst_n = 1;

        // Pass-through with no forwarding match.
        set_id(1, 5, 7, 0, 1, 2, 3, 3'b000, 0, 1, 1, 0, 0);
        tick();
        verify();
        check("pass_srcA", srcA, 5);
        check("pass_srcB", srcB, 7);
        check("pass_valid", ex_valid, 1);

        // Forward priority: EX/MEM over MEM/WB, register 0 never forwarded.
        set_id(1, 32'h11, 32'h22, 0, 3, 1, 2, 3'b001, 0, 1, 1, 0, 0);
        tick();
        set_fwd(1, 3, 32'hAA, 1, 3, 32'hBB);
        verify();
        check("fwd_exm_prio", srcA, 32'hAA);
        exm_reg_write = 0;
        verify();
        check("fwd_wb", srcA, 32'hBB);
        set_id(1, 32'h22, 32'h44, 0, 0, 0, 2, 3'b010, 0, 0, 1, 0, 0);
        tick();
        set_fwd(1, 0, 32'hAA, 1, 0, 32'hBB);
        verify();
        check("fwd_r0", srcA, 32'h22);

        // Immediate operand while store data still gets the forwarded rt.
        set_id(1, 1, 32'h33, 32'hFFFF_FFFC, 1, 4, 5, 3'b000, 1, 0, 0, 1, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        tick();
        set_fwd(1, 4, 9, 0, 0, 0);
        verify();
        check("imm_srcB", srcB, 32'hFFFF_FFFC);
        check("store_data", ex_write_data, 9);

        // Stall holds across two cycles while the decode side changes.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 5, 7, 0, 1, 2, 3, 3'b011, 0, 1, 1, 1, 0);
        tick();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            set_id(1, $urandom, $urandom, $urandom, 2, 3, 4, 3'b001, 1, 0, 0, 0, 1);
            tick();
            verify();
            check("stall_srcA", srcA, 5);
            check("stall_mw", ex_mem_write, 1);
        end
        flush = 1;
        tick();
        verify();
        check("flush_valid", ex_valid, 0);
        check("flush_mw", ex_mem_write, 0);
        stall = 0; flush = 0;

        // Illegal op suppresses writes.
        set_id(1, 1, 2, 0, 1, 2, 3, 3'b110, 0, 1, 1, 1, 1);
        tick();
        verify();
        check("illegal_flag", ex_illegal_op, 1);
        check("illegal_rw", ex_reg_write, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            verify();
            tick();
        end
        stall = 0; flush = 0;

        // Asynchronous reset mid-cycle with a loaded stage.
        set_id(1, 32'h55, 32'h66, 0, 1, 2, 3, 3'b000, 0, 1, 1, 1, 1);
        set_fwd(0, 0, 0, 0, 0, 0);
        tick();
        verify();
        #2 rst_n = 0;
        #1;
        model_reset();
        check("areset_valid", ex_valid, 0);
        check("areset_rw", ex_reg_write, 0);
        check("areset_srcA", srcA, 0);
        check("areset_srcB", srcB, 0);
        verify();
        @(negedge clk);
        rst_n = 1;
        tick();
        verify();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
